// File: rtl/pipe_pkg.sv
// Shared field layout and control-bit map for the
// clocked stage boundaries of the datapath.
package pipe_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  localparam int EXMEM_ALUOUT_OFS   = 0;
  localparam int EXMEM_MEMWDATA_OFS = EXMEM_ALUOUT_OFS + XLEN;
  localparam int EXMEM_WRITEREG_OFS = EXMEM_MEMWDATA_OFS + XLEN;
  localparam int EXMEM_PCPLUS4_OFS  = EXMEM_WRITEREG_OFS + REG_W;
  localparam int EXMEM_PCNEXT_OFS   = EXMEM_PCPLUS4_OFS + XLEN;
  localparam int EXMEM_W            = EXMEM_PCNEXT_OFS + XLEN;

  localparam int IFID_W  = 2 * XLEN;
  localparam int IDEX_W  = 4 * XLEN + 3 * REG_W;
  localparam int MEMWB_W = 3 * XLEN + REG_W;

  localparam int CTRL_BRANCH     = 0;
  localparam int CTRL_JUMP       = 1;
  localparam int CTRL_JUMPTOREG  = 2;
  localparam int CTRL_ZERO       = 3;
  localparam int CTRL_LINK       = 4;
  localparam int CTRL_MEMWRITE   = 5;
  localparam int CTRL_MEMTOREG   = 6;
  localparam int CTRL_REGWRITEEN = 7;
  localparam int CTRL_BITS       = 8;

  // Field order puts aluout in the LSBs, matching the offsets above.
  typedef struct packed {
    logic [XLEN-1:0]  pcnext;
    logic [XLEN-1:0]  pcplus4;
    logic [REG_W-1:0] writereg;
    logic [XLEN-1:0]  memwritedata;
    logic [XLEN-1:0]  aluout;
  } ex_mem_t;

endpackage

// File: rtl/pipe_stage_entry.sv
// One valid+ctrl+data holding register.
// Valid and ctrl reset; data is left unreset.
module pipe_stage_entry #(
  parameter int DATA_W = 133,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              q_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
    end else if (clear) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
    end else if (load) begin
      q_valid <= 1'b1;
      q_ctrl  <= d_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (load && !clear)
      q_data <= d_data;
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: valid/ready, flush,
// optional skid entry and saturating stall counter.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W = EXMEM_W,
  parameter int CTRL_W = CTRL_BITS,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic accept;
  logic emit;
  logic main_load;
  logic main_clear;

  assign accept = in_valid & in_ready;
  assign emit   = main_valid & out_ready;

  // A held skid entry always refills main first to keep order.
  assign main_load = ~flush &
    (skid_valid ? emit : (accept & (~main_valid | emit)));
  assign main_clear = flush | (emit & ~main_load);

  pipe_stage_entry #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk     (clk),
    .reset   (reset),
    .load    (main_load),
    .clear   (main_clear),
    .d_ctrl  (skid_valid ? skid_ctrl : in_ctrl),
    .d_data  (skid_valid ? skid_data : in_data),
    .q_valid (main_valid),
    .q_ctrl  (main_ctrl),
    .q_data  (main_data)
  );

  generate
    if (SKID) begin : g_skid
      logic skid_load;
      logic skid_clear;

      assign skid_load = ~flush & main_valid & ~skid_valid &
                         accept & ~emit;
      assign skid_clear = flush | (skid_valid & emit);

      pipe_stage_entry #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
      ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load    (skid_load),
        .clear   (skid_clear),
        .d_ctrl  (in_ctrl),
        .d_data  (in_data),
        .q_valid (skid_valid),
        .q_ctrl  (skid_ctrl),
        .q_data  (skid_data)
      );

      assign in_ready = ~skid_valid;
    end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign skid_ctrl  = '0;
      assign skid_data  = '0;
      assign in_ready   = ~main_valid | out_ready;
    end
  endgenerate

  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl & {CTRL_W{main_valid}};
  assign out_data  = main_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (main_valid && !out_ready && !flush && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench: skid stage (A) and a 4-bit
// counter, no-skid stage (B) on a shared clock.
module tb_pipe_stage_elastic;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         a_in_valid, a_in_ready, a_out_valid;
  logic         a_out_ready, a_flush;
  logic [7:0]   a_in_ctrl, a_out_ctrl;
  logic [132:0] a_in_data, a_out_data;
  logic [15:0]  a_stall;

  logic         b_in_valid, b_in_ready, b_out_valid;
  logic         b_out_ready, b_flush;
  logic [7:0]   b_in_ctrl, b_out_ctrl;
  logic [15:0]  b_in_data, b_out_data;
  logic [3:0]   b_stall;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_stage_elastic #(
    .DATA_W (133), .CTRL_W (8), .SKID (1'b1), .CNT_W (16)
  ) dut_a (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_ctrl   (a_in_ctrl),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_ctrl  (a_out_ctrl),
    .out_data  (a_out_data),
    .flush     (a_flush),
    .stall_cnt (a_stall)
  );

  pipe_stage_elastic #(
    .DATA_W (16), .CTRL_W (8), .SKID (1'b0), .CNT_W (4)
  ) dut_b (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_ctrl   (b_in_ctrl),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_ctrl  (b_out_ctrl),
    .out_data  (b_out_data),
    .flush     (b_flush),
    .stall_cnt (b_stall)
  );

  task automatic test_reset;
    a_in_valid = 0; a_out_ready = 0; a_flush = 0;
    a_in_ctrl = 0; a_in_data = '0;
    b_in_valid = 0; b_out_ready = 0; b_flush = 0;
    b_in_ctrl = 0; b_in_data = '0;
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({a_out_valid, a_out_ctrl, a_in_ready} !== {1'b0, 8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_a v=%b c=%h r=%b exp 0/00/1",
               a_out_valid, a_out_ctrl, a_in_ready);
    end
    n_tests++;
    if (a_stall !== 16'd0 || b_stall !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_cnt a=%0d b=%0d exp 0/0", a_stall, b_stall);
    end
    n_tests++;
    if ({b_out_valid, b_out_ctrl, b_in_ready} !== {1'b0, 8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_b v=%b c=%h r=%b exp 0/00/1",
               b_out_valid, b_out_ctrl, b_in_ready);
    end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_stream;
    a_out_ready = 1;
    a_in_valid  = 1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i <= 5) begin
        a_in_data = 133'(i);
        a_in_ctrl = 8'h80 | 8'(i);
      end else begin
        a_in_valid = 0;
      end
      n_tests++;
      if (a_in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_ready i=%0d got=%b exp=1", i, a_in_ready);
      end
      if (i > 1) begin
        n_tests++;
        if (a_out_valid !== 1'b1 || a_out_data !== 133'(i - 1) ||
            a_out_ctrl !== (8'h80 | 8'(i - 1))) begin
          n_fail++;
          $display("FAIL stream_out i=%0d v=%b d=%0h c=%h exp 1/%0h/%h",
                   i, a_out_valid, a_out_data, a_out_ctrl,
                   i - 1, 8'h80 | 8'(i - 1));
        end
      end
    end
    @(negedge clk);
    n_tests++;
    if (a_out_valid !== 1'b0 || a_out_ctrl !== 8'h00 || a_stall !== 16'd0) begin
      n_fail++;
      $display("FAIL stream_end v=%b c=%h cnt=%0d exp 0/00/0",
               a_out_valid, a_out_ctrl, a_stall);
    end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    a_out_ready = 0; a_in_valid = 1;
    a_in_data = 133'hA; a_in_ctrl = 8'h0A;
    @(negedge clk);
    a_in_data = 133'hB; a_in_ctrl = 8'h0B;
    n_tests++;
    if (a_in_ready !== 1'b1 || a_out_data !== 133'hA) begin
      n_fail++;
      $display("FAIL bp_one r=%b d=%0h exp 1/a", a_in_ready, a_out_data);
    end
    @(negedge clk);
    a_in_data = 133'hC; a_in_ctrl = 8'h0C;
    n_tests++;
    if (a_in_ready !== 1'b0 || a_out_data !== 133'hA ||
        a_out_ctrl !== 8'h0A) begin
      n_fail++;
      $display("FAIL bp_full r=%b d=%0h c=%h exp 0/a/0a",
               a_in_ready, a_out_data, a_out_ctrl);
    end
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (a_stall !== 16'd3 || a_out_data !== 133'hA || a_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_hold cnt=%0d d=%0h r=%b exp 3/a/0",
               a_stall, a_out_data, a_in_ready);
    end
    a_out_ready = 1;
    @(negedge clk);
    n_tests++;
    if (a_out_valid !== 1'b1 || a_out_data !== 133'hB || a_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_drain_b v=%b d=%0h r=%b exp 1/b/1",
               a_out_valid, a_out_data, a_in_ready);
    end
    @(negedge clk);
    a_in_valid = 0;
    n_tests++;
    if (a_out_valid !== 1'b1 || a_out_data !== 133'hC || a_out_ctrl !== 8'h0C) begin
      n_fail++;
      $display("FAIL bp_drain_c v=%b d=%0h c=%h exp 1/c/0c",
               a_out_valid, a_out_data, a_out_ctrl);
    end
    @(negedge clk);
    n_tests++;
    if (a_out_valid !== 1'b0 || a_stall !== 16'd3) begin
      n_fail++;
      $display("FAIL bp_empty v=%b cnt=%0d exp 0/3", a_out_valid, a_stall);
    end
  endtask

  task automatic test_flush;
    a_out_ready = 0; a_in_valid = 1;
    a_in_data = 133'hE; a_in_ctrl = 8'hE1;
    @(negedge clk);
    a_in_data = 133'hF; a_in_ctrl = 8'hF1;
    @(negedge clk);
    a_in_data = 133'hD; a_in_ctrl = 8'hD1;
    a_flush = 1;
    n_tests++;
    if (a_in_ready !== 1'b0 || a_stall !== 16'd4) begin
      n_fail++;
      $display("FAIL flush_pre r=%b cnt=%0d exp 0/4", a_in_ready, a_stall);
    end
    @(negedge clk);
    n_tests++;
    if (a_out_valid !== 1'b0 || a_out_ctrl !== 8'h00 ||
        a_in_ready !== 1'b1 || a_stall !== 16'd4) begin
      n_fail++;
      $display("FAIL flush_full v=%b c=%h r=%b cnt=%0d exp 0/00/1/4",
               a_out_valid, a_out_ctrl, a_in_ready, a_stall);
    end
    // empty stage: D is handshaken in the flush cycle and dropped
    n_tests++;
    if (a_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_accept r=%b exp 1", a_in_ready);
    end
    @(negedge clk);
    a_flush = 0; a_in_valid = 0; a_out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (a_out_valid !== 1'b0 || a_out_ctrl !== 8'h00) begin
        n_fail++;
        $display("FAIL flush_leak i=%0d v=%b c=%h exp 0/00",
                 i, a_out_valid, a_out_ctrl);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_bubble;
    a_in_valid = 0; a_in_ctrl = 8'hFF; a_out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if (a_out_valid !== 1'b0 || a_out_ctrl !== 8'h00) begin
        n_fail++;
        $display("FAIL bubble i=%0d v=%b c=%h exp 0/00",
                 i, a_out_valid, a_out_ctrl);
      end
    end
  endtask

  task automatic test_reset_midstream;
    a_out_ready = 0; a_in_valid = 1;
    a_in_data = 133'h11; a_in_ctrl = 8'hC3;
    @(negedge clk);
    a_in_data = 133'h22;
    @(negedge clk);
    a_in_valid = 0;
    n_tests++;
    if (a_in_ready !== 1'b0 || a_out_ctrl !== 8'hC3) begin
      n_fail++;
      $display("FAIL mid_full r=%b c=%h exp 0/c3", a_in_ready, a_out_ctrl);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({a_out_valid, a_out_ctrl, a_in_ready} !== {1'b0, 8'h00, 1'b1} ||
        a_stall !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_reset v=%b c=%h r=%b cnt=%0d exp 0/00/1/0",
               a_out_valid, a_out_ctrl, a_in_ready, a_stall);
    end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_noskid_sat;
    b_out_ready = 0; b_in_valid = 1;
    b_in_data = 16'h1234; b_in_ctrl = 8'h5A;
    @(negedge clk);
    b_in_data = 16'h5678; b_in_ctrl = 8'hA5;
    for (int k = 0; k < 20; k++) begin
      n_tests++;
      if (b_in_ready !== 1'b0 || b_out_valid !== 1'b1 ||
          b_stall !== 4'(k > 15 ? 15 : k)) begin
        n_fail++;
        $display("FAIL sat k=%0d r=%b v=%b cnt=%0d exp 0/1/%0d",
                 k, b_in_ready, b_out_valid, b_stall, k > 15 ? 15 : k);
      end
      @(negedge clk);
    end
    b_out_ready = 1;
    #1;
    n_tests++;
    if (b_in_ready !== 1'b1 || b_out_data !== 16'h1234 || b_stall !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_release r=%b d=%h cnt=%0d exp 1/1234/15",
               b_in_ready, b_out_data, b_stall);
    end
    @(negedge clk);
    b_in_valid = 0;
    n_tests++;
    if (b_out_data !== 16'h5678 || b_out_ctrl !== 8'hA5 || b_stall !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_next d=%h c=%h cnt=%0d exp 5678/a5/15",
               b_out_data, b_out_ctrl, b_stall);
    end
    @(negedge clk);
    n_tests++;
    if (b_out_valid !== 1'b0 || b_out_ctrl !== 8'h00) begin
      n_fail++;
      $display("FAIL sat_empty v=%b c=%h exp 0/00", b_out_valid, b_out_ctrl);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_bubble();
    test_reset_midstream();
    test_noskid_sat();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised pipeline register that replaces the pass-through stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB) with a real clocked stage.
- Carries a payload bus plus a control bus that is forced to zero whenever the stage holds a bubble, so bubbles never write memory or registers.
- Supports valid/ready back-pressure (stall), flush for branch/jump redirect, an optional one-entry skid buffer, and a saturating stall counter.
- Instantiated once per stage boundary in the datapath.

Parameters:
DATA_W, 133, payload width (aluout, memwritedata, writereg, pcplus4, pcnext for EX/MEM)
CTRL_W, 8, control-bit width (branch, jump, jumptoreg, zero, link, memwrite, memtoreg, regwriteen); zeroed on bubble
SKID, 1, 1 = two-entry elastic stage with registered in_ready; 0 = single register with combinational in_ready
CNT_W, 16, width of the stall counter

Ports:
clk  input  1  stage clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  upstream holds a valid instruction
in_ready  output  1  stage accepts this cycle
in_ctrl  input  CTRL_W  upstream control bits
in_data  input  DATA_W  upstream payload
out_valid  output  1  stage holds a valid instruction
out_ready  input  1  downstream accepts this cycle
out_ctrl  output  CTRL_W  control bits; 0 when out_valid=0
out_data  output  DATA_W  payload; don't-care when out_valid=0
flush  input  1  kill all held and incoming instructions this cycle
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Reset (reset=0, asynchronous): main_valid=0, skid_valid=0, stall_cnt=0, and both ctrl registers cleared to 0. The result is out_valid=0, out_ctrl=0, in_ready=1. Data registers are not reset.
- Transfers: accept = in_valid & in_ready; emit = out_valid & out_ready. Latency is 1 cycle from accept to out_valid when the stage is empty.
- out_ctrl = main_ctrl & {CTRL_W{main_valid}}. out_data = main_data.
- SKID=0:
  - in_ready = ~main_valid | out_ready (combinational).
  - On accept, main loads the input and main_valid=1.
  - On emit without accept, main_valid=0.
- SKID=1:
  - in_ready = ~skid_valid (registered; no combinational path from out_ready).
  - States by {skid_valid, main_valid}:
    - EMPTY {0,0}: accept -> main loads, go to ONE.
    - ONE {0,1}:
      - accept & emit -> main reloads, stay in ONE.
      - accept & ~emit -> skid loads, go to FULL.
      - emit only -> go to EMPTY.
    - FULL {1,1}: no accept possible. Emit -> main <= skid, skid_valid=0, go to ONE.
  - Order is preserved: skid always holds the younger instruction.
- Flush: has priority over every simultaneous accept/emit. Next cycle main_valid=0, skid_valid=0 (stage EMPTY) and the input that cycle is discarded.
  - in_ready during flush keeps its normal value, so upstream sees its instruction as consumed.
  - An emit in the flush cycle still completes downstream; flush acts only on the stage's next state.
- stall_cnt increments when out_valid & ~out_ready & ~flush. It holds at 2^CNT_W-1 and is unaffected by flush.
- Control bits never leak: after flush or emit, out_ctrl is 0 in the same cycle out_valid drops.

Decomposition:
- Shared package pipe_pkg holds:
  - EX/MEM field widths and offsets into DATA_W.
  - Control-bit index constants (CTRL_BRANCH=0 … CTRL_REGWRITEEN=7).
  - Derived DATA_W/CTRL_W per stage boundary.
- One natural sub-module: pipe_stage_entry, a single valid+ctrl+data register with load/clear. It is instantiated as main, and as skid when SKID=1.
- Per-stage wrappers (e.g. pipe_ex2mem) pack and unpack named fields into this block.

Test Plan:
- Reset mid-stream: stage FULL, assert reset=0 asynchronously between edges -> out_valid=0, out_ctrl=8'h00, in_ready=1, stall_cnt=0 immediately, with no clock edge needed.
- Streaming, SKID=1: in_valid=1 every cycle with data 1,2,3,… and out_ready=1 -> out_data follows input one cycle later at one per cycle, in_ready stays 1.
- Back-pressure, SKID=1: out_ready=0 while sending A, B, C ->
  - A held in main, B in skid, in_ready=0, C held upstream.
  - After out_ready=1: emitted order is A, B, C with no loss or duplication.
  - stall_cnt equals the number of stalled cycles.
- Flush in FULL state with simultaneous in_valid=1 (data D) -> next cycle out_valid=0, out_ctrl=0, D never appears on out_data.
- Bubble gating: in_valid=0 with in_ctrl=8'hFF -> out_ctrl stays 8'h00, out_valid=0.
- SKID=0 and counter saturation, with CNT_W=4 and out_ready=0 for 20 cycles ->
  - in_ready = out_ready while the stage is full.
  - stall_cnt reaches 15 and holds there.
